fde_sequencer: RTL

//  Parametrised fetch/decode/execute control unit for the processor core. It sequences the
//  ALU/register file, PC, RAM and ROM enables from a latched instruction register. Unlike the

---
 rtl/processor_pkg.sv | 87 ++++++++
 rtl/seq_wait_timer.sv | 42 ++++
 rtl/fde_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// -----------------------------------------------------------------------------
// processor_pkg
//   Shared definitions for the fetch/decode/execute sequencer:
//   - state_t     : sequencer state encoding (also exported on the debug port)
//   - CLS_*       : opcode class constants (top byte of the instruction)
//   - NIB_*       : top-nibble groups that run with no DECODE enables
//   - enables_t   : bundle of the datapath enables
//   - decode_t    : decoded view of one opcode class
//   - decode_class: class byte -> enables / memory wait / output op / legality
// -----------------------------------------------------------------------------
package processor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_HALT    = 3'd5,
    ST_FAULT   = 3'd6,
    ST_UNUSED  = 3'd7
  } state_t;

  localparam logic [7:0] CLS_ALU_OUT    = 8'h22; // register file -> output port
  localparam logic [7:0] CLS_RAM_OUT    = 8'h42; // RAM -> output port
  localparam logic [7:0] CLS_RAM_WR     = 8'h41; // bus -> RAM
  localparam logic [7:0] CLS_ROM_TO_RAM = 8'h31; // ROM data word -> RAM
  localparam logic [7:0] CLS_RAM_TO_ALU = 8'h92; // RAM -> register file
  localparam logic [7:0] CLS_ALU_TO_RAM = 8'h91; // register file -> RAM

  localparam logic [3:0] NIB_ALU     = 4'h1;
  localparam logic [3:0] NIB_JMP_RAM = 4'h7;
  localparam logic [3:0] NIB_JMP_IMM = 4'hF;

  // An all-zero instruction word is HALT; compared as ir == '0 so it scales
  // with DATA_WIDTH.

  typedef struct packed {
    logic pc_read;
    logic rom;
    logic rom_read_data;
    logic ram_read;
    logic ram_write;
    logic alu_read;
    logic alu_write;
    logic pc;
  } enables_t;

  typedef struct packed {
    enables_t en;        // enables driven during DECODE
    logic     needs_mem; // DECODE waits for mem_ready
    logic     out_op;    // data_in is captured into the output port
    logic     legal;     // class is recognised
  } decode_t;

  function automatic decode_t decode_class(input logic [7:0] cls);
    decode_t d;
    d = '0;
    d.legal = 1'b1;
    case (cls)
      CLS_ALU_OUT:    begin d.en.alu_read = 1'b1; d.out_op = 1'b1; end
      CLS_RAM_OUT:    begin d.en.ram_read = 1'b1; d.out_op = 1'b1; d.needs_mem = 1'b1; end
      CLS_RAM_WR:     begin d.en.ram_write = 1'b1; d.needs_mem = 1'b1; end
      CLS_ROM_TO_RAM: begin
        d.en.rom_read_data = 1'b1;
        d.en.ram_write     = 1'b1;
        d.needs_mem        = 1'b1;
      end
      CLS_RAM_TO_ALU: begin
        d.en.ram_read  = 1'b1;
        d.en.alu_write = 1'b1;
        d.needs_mem    = 1'b1;
      end
      CLS_ALU_TO_RAM: begin
        d.en.alu_read  = 1'b1;
        d.en.ram_write = 1'b1;
        d.needs_mem    = 1'b1;
      end
      default: begin
        d.legal = (cls[7:4] == NIB_ALU) || (cls[7:4] == NIB_JMP_RAM) ||
                  (cls[7:4] == NIB_JMP_IMM);
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// -----------------------------------------------------------------------------
// seq_wait_timer
//   Counts consecutive stalled cycles within one sequencer state and flags a
//   timeout on the stalled cycle that reaches TIMEOUT_CYCLES.
// Ports:
//   clk       in  system clock
//   reset     in  asynchronous, active-high
//   stall_i   in  current state is waiting on mem_ready this cycle
//   clear_i   in  sequencer changes state at the next edge
//   timeout_o out this stalled cycle is the TIMEOUT_CYCLES-th in a row
// -----------------------------------------------------------------------------
module seq_wait_timer #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic stall_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear_i)      wait_cnt_d = '0;
    else if (stall_i) wait_cnt_d = wait_cnt_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign timeout_o = stall_i && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fde_sequencer.sv
// -----------------------------------------------------------------------------
// fde_sequencer
//   Fetch/decode/execute control unit. Latches the instruction into ir at the
//   end of FETCH and drives the datapath enables combinationally from
//   (state, ir). Memory stalls hold all enables; a run of TIMEOUT_CYCLES
//   stalls forces FAULT. HALT (ir == 0) and FAULT are sticky until reset.
// Ports:
//   clk, reset (async, active-high)
//   opcode_in, data_in, mem_ready, run, step               inputs
//   pc_read_enable .. pc_enable                            datapath enables
//   data_output / data_output_valid                        registered output port
//   halted, fault, state, instr_count                      status / debug
// -----------------------------------------------------------------------------
module fde_sequencer
  import processor_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_WIDTH      = 32,
  parameter bit STRICT_DECODE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opcode_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  mem_ready,
  input  logic                  run,
  input  logic                  step,
  output logic                  pc_read_enable,
  output logic                  rom_enable,
  output logic                  rom_read_data_enable,
  output logic                  ram_read_enable,
  output logic                  ram_write_enable,
  output logic                  alu_read_enable,
  output logic                  alu_write_enable,
  output logic                  pc_enable,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  data_output_valid,
  output logic                  halted,
  output logic                  fault,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  state_t                state_q, state_d, nxt_state;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  enables_t   en;
  decode_t    dec;
  logic [7:0] cls;
  logic [3:0] nib;
  logic       stall;
  logic       timeout;

  assign cls = ir_q[DATA_WIDTH-1 -: 8];
  assign nib = cls[7:4];
  assign dec = decode_class(cls);

  // Next-state and enables without the timeout override; kept apart from the
  // override so the stall -> timeout -> next-state path has no feedback.
  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    nxt_state = state_q;
    ir_d      = ir_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    count_d   = count_q;
    en        = '0;
    stall     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run || step) nxt_state = ST_FETCH;
      end
      ST_FETCH: begin
        en.pc_read = 1'b1;
        en.rom     = 1'b1;
        if (mem_ready) begin
          ir_d      = opcode_in;
          nxt_state = ST_DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      ST_DECODE: begin
        if (ir_q == '0) begin
          nxt_state = ST_HALT;
        end else if (!dec.legal && STRICT_DECODE) begin
          nxt_state = ST_FAULT;
        end else begin
          en = dec.en;
          if (dec.needs_mem && !mem_ready) begin
            stall = 1'b1;
          end else begin
            nxt_state = ST_EXECUTE;
            if (dec.out_op) begin
              dout_d  = data_in;
              valid_d = 1'b1;
            end
          end
        end
      end
      ST_EXECUTE: begin
        en.alu_write = (nib == NIB_ALU);
        nxt_state    = ST_COMMIT;
      end
      ST_COMMIT: begin
        en.pc = 1'b1;
        if (nib == NIB_JMP_RAM) begin
          en.ram_read = 1'b1;
          stall       = !mem_ready;
        end
        if (!stall) begin
          count_d   = count_q + CNT_WIDTH'(1);
          nxt_state = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT:  nxt_state = ST_HALT;
      ST_FAULT: nxt_state = ST_FAULT;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  assign state_d = timeout ? ST_FAULT : nxt_state;

  seq_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .stall_i  (stall),
    .clear_i  (state_d != state_q),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign pc_read_enable       = en.pc_read;
  assign rom_enable           = en.rom;
  assign rom_read_data_enable = en.rom_read_data;
  assign ram_read_enable      = en.ram_read;
  assign ram_write_enable     = en.ram_write;
  assign alu_read_enable      = en.alu_read;
  assign alu_write_enable     = en.alu_write;
  assign pc_enable            = en.pc;
  assign data_output          = dout_q;
  assign data_output_valid    = valid_q;
  assign halted               = (state_q == ST_HALT);
  assign fault                = (state_q == ST_FAULT);
  assign state                = state_q;
  assign instr_count          = count_q;

endmodule
